// File: rtl/pulse_period_meter.sv
// Measures high time, low time and period of an asynchronous square wave
// in clk cycles, with a sticky stuck-input flag.
module pulse_period_meter #(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period_cnt,
    output logic             meas_valid,
    output logic             timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   edge_det;
    logic                   tmo_hit;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] hi_len_q, hi_len_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W:0]   period_q, period_d;
    logic             valid_q, valid_d;
    logic             tmo_q, tmo_d;

    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = s & ~s_prev_q;
    assign fall     = ~s & s_prev_q;
    assign edge_det = rise | fall;
    assign tmo_hit  = (run_cnt_q == TMO_C);

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        hi_len_d  = hi_len_q;
        high_d    = high_q;
        low_d     = low_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        tmo_d     = tmo_q;
        if (!enable) begin
            state_d   = S_IDLE;
            run_cnt_d = '0;
            tmo_d     = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    run_cnt_d = '0;
                    tmo_d     = 1'b0;
                    state_d   = S_ARM;
                end
                default: begin
                    // An edge always beats the timeout in the same cycle
                    if (edge_det) begin
                        run_cnt_d = ONE_C;
                        tmo_d     = 1'b0;
                        if (state_q == S_ARM && rise) begin
                            state_d = S_HIGH;
                        end else if (state_q == S_HIGH && fall) begin
                            hi_len_d = run_cnt_q;
                            state_d  = S_LOW;
                        end else if (state_q == S_LOW && rise) begin
                            high_d   = hi_len_q;
                            low_d    = run_cnt_q;
                            period_d = {1'b0, hi_len_q} + {1'b0, run_cnt_q};
                            valid_d  = 1'b1;
                            state_d  = S_HIGH;
                        end
                    end else if (tmo_hit) begin
                        tmo_d     = 1'b1;
                        run_cnt_d = '0;
                        state_d   = S_ARM;
                    end else begin
                        run_cnt_d = run_cnt_q + ONE_C;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            s_prev_q  <= 1'b0;
            state_q   <= S_IDLE;
            run_cnt_q <= '0;
            hi_len_q  <= '0;
            high_q    <= '0;
            low_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            s_prev_q  <= s;
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            hi_len_q  <= hi_len_d;
            high_q    <= high_d;
            low_q     <= low_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            tmo_q     <= tmo_d;
        end
    end

    assign high_cnt   = high_q;
    assign low_cnt    = low_q;
    assign period_cnt = period_q;
    assign meas_valid = valid_q;
    assign timeout    = tmo_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: fixed phase sequences with
// hand-computed counts, sampled on the falling clock edge.
module tb_pulse_period_meter;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        pulse_in;
    logic [23:0] high_cnt;
    logic [23:0] low_cnt;
    logic [24:0] period_cnt;
    logic        meas_valid;
    logic        timeout;

    int n_chk;
    int n_pass;
    int cyc;
    int vcnt;
    int tcnt;
    int last_cyc;
    int last_gap;
    int hi_s;
    int lo_s;
    int per_s;
    int v0;
    int t0;

    pulse_period_meter #(
        .CNT_W(24),
        .SYNC_STAGES(2),
        .TIMEOUT(1000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .pulse_in(pulse_in),
        .high_cnt(high_cnt),
        .low_cnt(low_cnt),
        .period_cnt(period_cnt),
        .meas_valid(meas_valid),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc      = 0;
        vcnt     = 0;
        tcnt     = 0;
        last_cyc = 0;
        last_gap = 0;
        hi_s     = 0;
        lo_s     = 0;
        per_s    = 0;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (meas_valid) begin
            vcnt     = vcnt + 1;
            last_gap = cyc - last_cyc;
            last_cyc = cyc;
            hi_s     = int'(high_cnt);
            lo_s     = int'(low_cnt);
            per_s    = int'(period_cnt);
        end
        if (timeout) tcnt = tcnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk = n_chk + 1;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass = n_pass + 1;
    endtask

    task automatic phase(input logic lvl, input int n);
        pulse_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_meas(input string tag, input int nv,
                              input int hi, input int lo);
        check({tag, "_nvalid"}, vcnt - v0, nv);
        check({tag, "_high"}, hi_s, hi);
        check({tag, "_low"}, lo_s, lo);
        check({tag, "_period"}, per_s, hi + lo);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_high0"}, int'(high_cnt), 0);
        check({tag, "_low0"}, int'(low_cnt), 0);
        check({tag, "_per0"}, int'(period_cnt), 0);
        check({tag, "_valid0"}, int'(meas_valid), 0);
        check({tag, "_tmo0"}, int'(timeout), 0);
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        pulse_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: 51/51 square wave
        v0     = vcnt;
        enable = 1'b1;
        phase(1'b0, 60);
        for (int i = 0; i < 4; i++) begin
            phase(1'b1, 51);
            phase(1'b0, 51);
        end
        phase(1'b1, 10);
        check_meas("t1", 4, 51, 51);
        check("t1_gap", last_gap, 102);

        // T2: 10 high / 30 low
        v0 = vcnt;
        phase(1'b0, 30);
        for (int i = 0; i < 3; i++) begin
            phase(1'b1, 10);
            phase(1'b0, 30);
        end
        phase(1'b1, 5);
        check_meas("t2", 4, 10, 30);
        check("t2_gap", last_gap, 40);

        // T3: stuck high for 1500 cycles
        v0 = vcnt;
        phase(1'b1, 1495);
        check("t3_tmo_set", int'(timeout), 1);
        check("t3_no_valid", vcnt - v0, 0);
        phase(1'b0, 20);
        check("t3_tmo_clr", int'(timeout), 0);
        phase(1'b1, 15);
        phase(1'b0, 25);
        phase(1'b1, 5);
        check_meas("t3", 1, 15, 25);

        // T6: 1000-cycle high segment, edge coincides with the limit
        v0 = vcnt;
        t0 = tcnt;
        phase(1'b1, 995);
        phase(1'b0, 20);
        phase(1'b1, 5);
        check_meas("t6", 1, 1000, 20);
        check("t6_no_tmo", tcnt - t0, 0);

        // 1001-cycle segment: timeout for exactly one cycle
        v0 = vcnt;
        t0 = tcnt;
        phase(1'b1, 996);
        phase(1'b0, 20);
        phase(1'b1, 5);
        check("t6b_tmo_cycles", tcnt - t0, 1);
        check("t6b_no_valid", vcnt - v0, 0);
        check("t6b_tmo_clr", int'(timeout), 0);

        // T4: enable dropped mid-LOW
        v0 = vcnt;
        phase(1'b0, 20);
        enable = 1'b0;
        phase(1'b0, 5);
        check("t4_hold_high", int'(high_cnt), 1000);
        check("t4_hold_low", int'(low_cnt), 20);
        check("t4_hold_per", int'(period_cnt), 1020);
        enable = 1'b1;
        phase(1'b0, 10);
        phase(1'b1, 10);
        phase(1'b0, 30);
        phase(1'b1, 5);
        check_meas("t4", 1, 10, 30);

        // T5: asynchronous reset mid-period
        phase(1'b1, 10);
        rst_n    = 1'b0;
        pulse_in = 1'b0;
        #2;
        check_zero("t5");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v0    = vcnt;
        phase(1'b0, 20);
        phase(1'b1, 12);
        phase(1'b0, 28);
        phase(1'b1, 5);
        check_meas("t5", 1, 12, 28);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
